// File: rtl/seq_mul_ctrl_if.sv
// Operand/result handshake bundle for the sequential multiplier controller.
// master = operand producer / product consumer, slave = the multiplier.
interface seq_mul_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface : seq_mul_ctrl_if

// File: rtl/seq_mul_ctrl.sv
// Shift-and-add multiplier controller driving an external WIDTH-bit adder.
// One partial product per cycle, fixed WIDTH-cycle latency, low WIDTH bits kept.
module seq_mul_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_mul_ctrl_if.slave    bus,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_step;
  logic             release_out;

  assign accept      = (state == IDLE) && bus.in_valid;
  assign last_step   = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
  assign release_out = (state == DONE) && bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; unused encoding falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept      ? BUSY : IDLE;
      BUSY:    state_nxt = last_step   ? DONE : BUSY;
      DONE:    state_nxt = release_out ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      m   <= '0;
      q   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= '0;
            m   <= bus.op_a;
            q   <= bus.op_b;
            cnt <= '0;
          end
        end
        BUSY: begin
          acc <= add_sum;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
          acc <= acc;
          m   <= m;
          q   <= q;
          cnt <= cnt;
        end
      endcase
    end
  end

  // Output decode; adder operands are forced to zero outside BUSY
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.product   = acc;
    busy          = 1'b0;
    add_a         = '0;
    add_b         = '0;
    case (state)
      IDLE: begin
        bus.in_ready = rst_n;
      end
      BUSY: begin
        busy  = 1'b1;
        add_a = acc;
        add_b = q[0] ? m : '0;
      end
      DONE: begin
        bus.out_valid = 1'b1;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule : seq_mul_ctrl

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: directed scenarios plus random back-to-back
// traffic compared against plain multiplication modulo 2^32.
module tb_seq_mul_ctrl;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;

  int n_assert;
  int n_fail;

  seq_mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_mul_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum)
  );

  // Attached ripple adder, combinational
  assign add_sum = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return full[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, time the BUSY phase, optionally stall the result, release
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] exp_p;
    logic [63:0] part;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          edges;
    int          busy_cnt;
    logic        ops_bad;
    exp_p          = ref_mul(a, b);
    bus.in_valid   = 1'b1;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.out_ready  = 1'b0;
    step();
    bus.in_valid   = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    ops_bad  = 1'b0;
    while (!bus.out_valid && edges < 40) begin
      if (busy) begin
        busy_cnt++;
        part  = 64'(a) * (64'(b) & ((64'd1 << edges) - 64'd1));
        exp_a = part[31:0];
        part  = 64'(a) << edges;
        exp_b = b[edges % 32] ? part[31:0] : 32'd0;
        if (add_a !== exp_a || add_b !== exp_b) ops_bad = 1'b1;
      end
      step();
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'd32);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({tag, "_adder_ops"}, 64'(ops_bad), 64'd0);
    chk({tag, "_product"}, 64'(bus.product), 64'(exp_p));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_product"}, 64'(bus.product), 64'(exp_p));
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_hold_out_valid"}, 64'(bus.out_valid), 64'd1);
    end
    chk({tag, "_done_adder_idle"}, {add_a, add_b}, 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] exp_q[$];
  logic [31:0] got_p;
  int          sent;
  int          got;
  int          cyc;
  int          edges;
  logic        acc_fire;
  logic        out_fire;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7, 0))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(15, 0));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(bus.product), 64'd0);
    chk("rst_adder", {add_a, add_b}, 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic op and boundary products
    do_op("t1_3x5", 32'd3, 32'd5, 0);
    do_op("t2_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("t2_wrap", 32'h0001_0000, 32'h0001_0000, 0);

    // Back-pressure on the result
    do_op("t3_stall", 32'd7, 32'd9, 10);

    // Asynchronous reset in the middle of an operation
    bus.in_valid = 1'b1;
    bus.op_a     = 32'd100;
    bus.op_b     = 32'd100;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    chk("t4_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_async_busy", 64'(busy), 64'd0);
    chk("t4_async_product", 64'(bus.product), 64'd0);
    chk("t4_async_adder", {add_a, add_b}, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t4_post_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t4_post_out_valid", 64'(bus.out_valid), 64'd0);
    do_op("t4_2x2", 32'd2, 32'd2, 0);

    // Operands offered during BUSY must be ignored
    bus.in_valid = 1'b1;
    bus.op_a     = 32'd6;
    bus.op_b     = 32'd7;
    step();
    bus.in_valid = 1'b0;
    edges = 0;
    repeat (5) begin step(); edges++; end
    bus.in_valid = 1'b1;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd1;
    repeat (3) begin
      chk("t5_in_ready_busy", 64'(bus.in_ready), 64'd0);
      step();
      edges++;
    end
    bus.in_valid = 1'b0;
    while (!bus.out_valid && edges < 40) begin step(); edges++; end
    chk("t5_latency", 64'(edges), 64'd32);
    chk("t5_product", 64'(bus.product), 64'd42);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("t5_no_capture", {62'd0, busy, bus.out_valid}, 64'd0);
    chk("t5_idle_ready", 64'(bus.in_ready), 64'd1);

    // Random back-to-back traffic with random consumer back-pressure
    sent = 0;
    got  = 0;
    cyc  = 0;
    ra   = pick_operand();
    rb   = pick_operand();
    while (got < 1000 && cyc < 90000) begin
      bus.in_valid  = (sent < 1000);
      bus.op_a      = ra;
      bus.op_b      = rb;
      bus.out_ready = ($urandom_range(3, 0) != 0);
      #1;
      acc_fire = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      if (out_fire) begin
        chk("rnd_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          got_p = exp_q.pop_front();
          chk("rnd_product", 64'(bus.product), 64'(got_p));
        end
        got++;
      end
      if (acc_fire) begin
        exp_q.push_back(ref_mul(ra, rb));
        sent++;
        ra = pick_operand();
        rb = pick_operand();
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rnd_count", 64'(got), 64'd1000);
    chk("rnd_leftover", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_seq_mul_ctrl
